xbus_ram_responder: RTL and testbench

//  XBus responder peripheral: a RAM with two XBus ports, A (address) and D (data).
//  It is the far end of the MC3999 x0/x1 handshake: it answers MC writes with a read-ack
//  and answers MC reads with a valid data word.
//  A-port writes/reads the shared pointer; D-port reads/writes mem[ptr], then ptr auto-increments modulo DEPTH.

---
 rtl/xbus_ram_responder_pkg.sv | 15 +
 rtl/xbus_ram_responder_if.sv | 26 ++
 rtl/xbus_ram_responder_slave_port.sv | 63 ++++++
 rtl/xbus_ram_responder.sv | 89 ++++++++
 tb/tb_xbus_ram_responder.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbus_ram_responder_pkg.sv
// Shared types and sizes for the XBus RAM responder: word width, RAM depth
// and the four-phase port handshake states.
package xbus_pkg;

    localparam int XBUS_WIDTH = 11;
    localparam int RAM_DEPTH  = 14;
    localparam int RAM_PTR_W  = 4;

    typedef enum logic [1:0] {
        XB_IDLE,
        XB_ACK,
        XB_VALID
    } xb_state_e;

endpackage

// File: rtl/xbus_ram_responder_if.sv
// One XBus port: MC-driven request side (master) and responder-driven
// acknowledge/data side (slave).
interface xbus_ram_responder_if
    import xbus_pkg::*;
#(
    parameter int WIDTH = XBUS_WIDTH
);

    logic             wr_req;
    logic [WIDTH-1:0] wr_dat;
    logic             rd_req;
    logic             rd_ack;
    logic             wr_valid;
    logic [WIDTH-1:0] dat_out;

    modport master (
        output wr_req, wr_dat, rd_req,
        input  rd_ack, wr_valid, dat_out
    );

    modport slave (
        input  wr_req, wr_dat, rd_req,
        output rd_ack, wr_valid, dat_out
    );

endinterface

// File: rtl/xbus_ram_responder_slave_port.sv
// Four-phase handshake for one XBus port. Accept pulses mark the edge on which
// the owner applies the side effect; read data is captured on that same edge.
module xbus_slave_port
    import xbus_pkg::*;
#(
    parameter int WIDTH = XBUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    xbus_ram_responder_if.slave  bus,
    input  logic [WIDTH-1:0]     rd_word,
    output logic                 accept_wr,
    output logic                 accept_rd,
    output logic [WIDTH-1:0]     wr_word
);

    xb_state_e        state_q;
    xb_state_e        state_d;
    logic [WIDTH-1:0] dat_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= XB_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            XB_IDLE: begin
                if (accept_wr)      state_d = XB_ACK;
                else if (accept_rd) state_d = XB_VALID;
            end
            XB_ACK:   if (!bus.wr_req) state_d = XB_IDLE;
            XB_VALID: if (!bus.rd_req) state_d = XB_IDLE;
            default:  state_d = XB_IDLE;
        endcase
    end

    // Write wins over a simultaneous read; the read is taken once the write completes.
    always_comb begin
        accept_wr    = 1'b0;
        accept_rd    = 1'b0;
        if (state_q == XB_IDLE && enable && !reset) begin
            accept_wr = bus.wr_req;
            accept_rd = bus.rd_req && !bus.wr_req;
        end
        bus.rd_ack   = (state_q == XB_ACK);
        bus.wr_valid = (state_q == XB_VALID);
    end

    always_ff @(posedge clk) begin
        if (reset)                                  dat_q <= '0;
        else if (accept_rd)                         dat_q <= rd_word;
        else if (state_q == XB_VALID && !bus.rd_req) dat_q <= '0;
    end

    assign bus.dat_out = dat_q;
    assign wr_word     = bus.wr_dat;

endmodule

// File: rtl/xbus_ram_responder.sv
// XBus RAM responder: A port reads/writes the shared pointer, D port accesses
// mem[ptr] with auto-increment. Optional power-up clear via XBUS_RAM_CLEAR_EN.
module xbus_ram_responder
    import xbus_pkg::*;
#(
    parameter int WIDTH = XBUS_WIDTH,
    parameter int DEPTH = RAM_DEPTH,
    parameter int PTR_W = RAM_PTR_W
) (
    input  logic                clk,
    input  logic                reset,
    xbus_ram_responder_if.slave a,
    xbus_ram_responder_if.slave d,
    output logic                busy
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic             port_en;
    logic             a_acc_wr, a_acc_rd_unused;
    logic             d_acc_wr, d_acc_rd;
    logic [WIDTH-1:0] a_word, d_word;
    logic [WIDTH-1:0] a_rd_word, d_rd_word;
    logic             clr_we;
    logic [PTR_W-1:0] clr_idx;

    assign port_en   = !busy;
    assign ptr_inc   = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    assign a_rd_word = WIDTH'(ptr);
    assign d_rd_word = mem[ptr];

    xbus_slave_port #(.WIDTH(WIDTH)) u_a_port (
        .clk       (clk),
        .reset     (reset),
        .enable    (port_en),
        .bus       (a),
        .rd_word   (a_rd_word),
        .accept_wr (a_acc_wr),
        .accept_rd (a_acc_rd_unused),
        .wr_word   (a_word)
    );

    xbus_slave_port #(.WIDTH(WIDTH)) u_d_port (
        .clk       (clk),
        .reset     (reset),
        .enable    (port_en),
        .bus       (d),
        .rd_word   (d_rd_word),
        .accept_wr (d_acc_wr),
        .accept_rd (d_acc_rd),
        .wr_word   (d_word)
    );

    // An A write on the same edge as a D access overrides the D increment.
    always_ff @(posedge clk) begin
        if (reset)                     ptr <= '0;
        else if (a_acc_wr)             ptr <= PTR_W'(a_word % WIDTH'(DEPTH));
        else if (d_acc_wr || d_acc_rd) ptr <= ptr_inc;
    end

    // NOTE: the RAM array has no reset; contents survive reset and are only cleared by the optional sequencer.
    always_ff @(posedge clk) begin
        if (clr_we)        mem[clr_idx] <= '0;
        else if (d_acc_wr) mem[ptr]     <= d_word;
    end

`ifdef XBUS_RAM_CLEAR_EN
    logic clr_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_active <= 1'b1;
            clr_idx    <= '0;
        end else if (clr_active) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == PTR_W'(DEPTH - 1)) clr_active <= 1'b0;
        end
    end

    assign clr_we = clr_active && !reset;
    assign busy   = clr_active;
`else
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
    assign busy    = 1'b0;
`endif

endmodule

// File: tb/tb_xbus_ram_responder.sv
// Randomized bench for xbus_ram_responder against a transaction-level model of
// the pointer and RAM; build with +define+XBUS_RAM_CLEAR_EN for the clear variant.
module tb_xbus_ram_responder;
    import xbus_pkg::*;

    localparam int W     = XBUS_WIDTH;
    localparam int DEPTH = RAM_DEPTH;
    localparam int PW    = RAM_PTR_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    xbus_ram_responder_if #(.WIDTH(W)) a_if ();
    xbus_ram_responder_if #(.WIDTH(W)) d_if ();

    xbus_ram_responder #(.WIDTH(W), .DEPTH(DEPTH), .PTR_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a_if),
        .d     (d_if),
        .busy  (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the RAM contents and pointer, updated per accepted access.
    logic [W-1:0] m_mem [DEPTH];
    int           m_ptr = 0;

    logic         exp_ack   [2];
    logic         exp_valid [2];
    logic [W-1:0] exp_dat   [2];
    bit           chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_rd_ack",   a_if.rd_ack,   exp_ack[0]);
            check("a_wr_valid", a_if.wr_valid, exp_valid[0]);
            check("a_dat_out",  a_if.dat_out,  exp_dat[0]);
            check("d_rd_ack",   d_if.rd_ack,   exp_ack[1]);
            check("d_wr_valid", d_if.wr_valid, exp_valid[1]);
            check("d_dat_out",  d_if.dat_out,  exp_dat[1]);
            check("busy",       busy,          1'b0);
        end
    end

    function automatic logic [W-1:0] model_read(input int p);
        if (p == 0) return W'(m_ptr);
        return m_mem[m_ptr];
    endfunction

    // Called right after an accepting edge. Both ports see the old pointer;
    // D commits first and an A write then overrides the pointer.
    task automatic accept_phase(input int p, input bit wr, input logic [W-1:0] wdat);
        int old;
        #1;
        old = m_ptr;
        if (wr) exp_ack[p] = 1'b1;
        else begin
            exp_valid[p] = 1'b1;
            exp_dat[p]   = model_read(p);
        end
        #1;
        if (p == 1) begin
            if (wr) m_mem[old] = wdat;
            m_ptr = (old + 1) % DEPTH;
        end
        #1;
        if (p == 0 && wr) m_ptr = int'(wdat) % DEPTH;
    endtask

    task automatic set_req(input int p, input bit wr, input bit rd, input logic [W-1:0] dat);
        if (p == 0) begin
            a_if.wr_req = wr; a_if.rd_req = rd; a_if.wr_dat = dat;
        end else begin
            d_if.wr_req = wr; d_if.rd_req = rd; d_if.wr_dat = dat;
        end
    endtask

    task automatic xfer(input int p, input bit wr, input logic [W-1:0] wdat,
                        input int hold, output logic [W-1:0] got);
        set_req(p, wr, !wr, wdat);
        @(posedge clk);
        accept_phase(p, wr, wdat);
        @(negedge clk);
        got = (p == 0) ? a_if.dat_out : d_if.dat_out;
        repeat (hold) begin @(posedge clk); #1; end
        set_req(p, 1'b0, 1'b0, wdat);
        @(posedge clk); #1;
        exp_ack[p] = 1'b0; exp_valid[p] = 1'b0; exp_dat[p] = '0;
    endtask

    // D port with write and read raised together: write first, then the read.
    task automatic wr_then_rd(input logic [W-1:0] wdat, input int hold, output logic [W-1:0] got);
        set_req(1, 1'b1, 1'b1, wdat);
        @(posedge clk);
        accept_phase(1, 1'b1, wdat);
        repeat (hold) begin @(posedge clk); #1; end
        d_if.wr_req = 1'b0;
        @(posedge clk); #1;
        exp_ack[1] = 1'b0;
        @(posedge clk);
        accept_phase(1, 1'b0, '0);
        @(negedge clk);
        got = d_if.dat_out;
        d_if.rd_req = 1'b0;
        @(posedge clk); #1;
        exp_valid[1] = 1'b0; exp_dat[1] = '0;
    endtask

`ifdef XBUS_RAM_CLEAR_EN
    task automatic wait_clear();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        check("clear_finished", n < 100, 1'b1);
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        @(posedge clk); #1;
    endtask
`endif

    logic [W-1:0] g0, g1, r, r2, mem0;
    int           op, h, h2, bc, n;
    bit           wa, wd;

    initial begin
        for (int p = 0; p < 2; p++) begin
            exp_ack[p] = 1'b0; exp_valid[p] = 1'b0; exp_dat[p] = '0;
        end
        set_req(0, 1'b0, 1'b0, '0);
        set_req(1, 1'b0, 1'b0, '0);

        @(negedge clk);
        check("rst_a_rd_ack",   a_if.rd_ack,   1'b0);
        check("rst_a_wr_valid", a_if.wr_valid, 1'b0);
        check("rst_a_dat_out",  a_if.dat_out,  '0);
        check("rst_d_rd_ack",   d_if.rd_ack,   1'b0);
        check("rst_d_wr_valid", d_if.wr_valid, 1'b0);
        check("rst_d_dat_out",  d_if.dat_out,  '0);
        @(posedge clk); #1;
        reset = 1'b0;

`ifdef XBUS_RAM_CLEAR_EN
        // Held D read must be ignored while the clear runs, then served.
        d_if.rd_req = 1'b1;
        bc = 0; n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            bc++;
            check("clr_req_ignored", d_if.wr_valid, 1'b0);
            @(negedge clk);
            n++;
        end
        check("clr_busy_cycles", bc, DEPTH);
        check("clr_valid_low_at_end", d_if.wr_valid, 1'b0);
        @(negedge clk);
        check("clr_first_read_valid", d_if.wr_valid, 1'b1);
        check("clr_first_read_zero",  d_if.dat_out,  '0);
        d_if.rd_req = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_ptr  = 1;
        chk_en = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            xfer(1, 1'b0, '0, 0, g1);
            check("clr_read_zero", g1, '0);
        end
`else
        check("busy_idle_zero", busy, 1'b0);
        chk_en = 1'b1;
`endif

        // Pointer write/read through A, ack held for several cycles.
        xfer(0, 1'b1, 11'd5, 3, g0);
        xfer(0, 1'b0, '0, 1, g0);
        check("t1_a_read_ptr", g0, 11'd5);

        // D writes auto-increment from 5; read them back.
        xfer(1, 1'b1, 11'd100, 0, g1);
        xfer(1, 1'b1, 11'd200, 2, g1);
        xfer(0, 1'b0, '0, 0, g0);
        check("t2_ptr_after_writes", g0, 11'd7);
        xfer(0, 1'b1, 11'd5, 0, g0);
        xfer(1, 1'b0, '0, 1, g1);
        check("t2_d_read_100", g1, 11'd100);
        xfer(1, 1'b0, '0, 0, g1);
        check("t2_d_read_200", g1, 11'd200);

        // Wrap and modulo behaviour of the pointer.
        xfer(0, 1'b1, 11'd13, 0, g0);
        xfer(1, 1'b1, 11'd7, 0, g1);
        xfer(0, 1'b0, '0, 0, g0);
        check("t3_wrap_to_0", g0, 11'd0);
        xfer(0, 1'b1, 11'd20, 0, g0);
        xfer(0, 1'b0, '0, 0, g0);
        check("t3_mod_20", g0, 11'd6);
        xfer(0, 1'b1, 11'h7FF, 0, g0);
        xfer(0, 1'b0, '0, 0, g0);
        check("t3_mod_2047", g0, 11'd3);

        // Fill the whole RAM with known data.
        xfer(0, 1'b1, '0, 0, g0);
        for (int i = 0; i < DEPTH; i++) begin
            r = W'($urandom);
            xfer(1, 1'b1, r, 0, g1);
        end

        // Same-edge A write and D read at ptr 9.
        xfer(0, 1'b1, 11'd9, 0, g0);
        fork
            xfer(0, 1'b1, 11'd2, 1, g0);
            xfer(1, 1'b0, '0, 0, g1);
        join
        check("t4_same_edge_d_old_ptr", g1, m_mem[9]);
        xfer(0, 1'b0, '0, 0, g0);
        check("t4_a_write_overrides", g0, 11'd2);
        wr_then_rd(11'h123, 1, g1);
        check("t4_read_after_write", g1, m_mem[3]);
        xfer(0, 1'b1, 11'd2, 0, g0);
        xfer(1, 1'b0, '0, 0, g1);
        check("t4_write_served_first", g1, 11'h123);

        // Randomized mix of single-port, same-edge and combined requests.
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 5);
            h  = $urandom_range(0, 3);
            h2 = $urandom_range(0, 3);
            r  = W'($urandom);
            r2 = W'($urandom);
            wa = 1'($urandom_range(0, 1));
            wd = 1'($urandom_range(0, 1));
            case (op)
                0: xfer(0, 1'b1, r, h, g0);
                1: xfer(0, 1'b0, '0, h, g0);
                2: xfer(1, 1'b1, r, h, g1);
                3: xfer(1, 1'b0, '0, h, g1);
                4: fork
                       xfer(0, wa, r, h, g0);
                       xfer(1, wd, r2, h2, g1);
                   join
                default: wr_then_rd(r, h, g1);
            endcase
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // Reset while D is presenting valid data aborts the handshake.
        d_if.rd_req = 1'b1;
        @(posedge clk);
        accept_phase(1, 1'b0, '0);
`ifdef XBUS_RAM_CLEAR_EN
        chk_en = 1'b0;
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        d_if.rd_req  = 1'b0;
        exp_valid[1] = 1'b0;
        exp_dat[1]   = '0;
        m_ptr        = 0;
        @(negedge clk);
        check("t5_valid_dropped", d_if.wr_valid, 1'b0);
        check("t5_dat_cleared",   d_if.dat_out,  '0);

        // A D write presented during reset must not touch memory.
        mem0 = m_mem[0];
        d_if.wr_dat = ~mem0;
        d_if.wr_req = 1'b1;
        reset       = 1'b1;
        @(posedge clk); #1;
        reset       = 1'b0;
        d_if.wr_req = 1'b0;
        @(negedge clk);
        check("t5_no_ack_in_reset", d_if.rd_ack, 1'b0);
`ifdef XBUS_RAM_CLEAR_EN
        wait_clear();
        chk_en = 1'b1;
        mem0   = m_mem[0];
`endif
        xfer(0, 1'b0, '0, 0, g0);
        check("t5_ptr_after_reset", g0, 11'd0);
        xfer(1, 1'b0, '0, 0, g1);
        check("t5_mem_untouched", g1, mem0);
        xfer(0, 1'b0, '0, 0, g0);
        check("t5_ptr_incremented", g0, 11'd1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
